// File: rtl/baccarat_pkg.sv
// Shared types for the baccarat round controller: FSM states, wager side codes, result codes.
package baccarat_pkg;

  typedef enum logic [2:0] {
    ST_BET,
    ST_DEAL,
    ST_SETTLE,
    ST_SHOW,
    ST_BROKE,
    ST_ERR
  } state_t;

  localparam logic [1:0] SIDE_PLAYER = 2'd1;
  localparam logic [1:0] SIDE_BANKER = 2'd2;
  localparam logic [1:0] SIDE_TIE    = 2'd3;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_BANKER = 2'b10;
  localparam logic [1:0] RES_TIE    = 2'b11;

endpackage

// File: rtl/baccarat_payout.sv
// Combinational settlement: returns the saturated bankroll after crediting a finished round.
// Optional macro BANKER_COMMISSION_EN takes a ~5% floor commission off winning banker bets.
module baccarat_payout
  import baccarat_pkg::*;
#(
  parameter int BANK_W = 16
) (
  input  logic [1:0]        side,
  input  logic [7:0]        amt,
  input  logic [1:0]        result,
  input  logic [BANK_W-1:0] bankroll,
  output logic [BANK_W-1:0] new_bankroll
);

  localparam int WW = BANK_W + 4;
  localparam logic [WW-1:0] BANK_MAX = WW'({BANK_W{1'b1}});

  logic [WW-1:0] amt_w, banker_credit, credit, sum;

  always_comb begin
    amt_w = WW'(amt);
`ifdef BANKER_COMMISSION_EN
    banker_credit = (amt_w << 1) - ((amt_w * WW'(13)) >> 8);
`else
    banker_credit = amt_w << 1;
`endif
    credit = '0;
    if (result == RES_TIE)
      // Player/banker bets push on a tie: stake comes back.
      credit = (side == SIDE_TIE) ? (amt_w * WW'(9)) : amt_w;
    else if (side == SIDE_PLAYER && result == RES_PLAYER)
      credit = amt_w << 1;
    else if (side == SIDE_BANKER && result == RES_BANKER)
      credit = banker_credit;
    sum = WW'(bankroll) + credit;
    new_bankroll = (sum > BANK_MAX) ? {BANK_W{1'b1}} : sum[BANK_W-1:0];
  end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Round controller above the card-dealing FSM: takes wagers, meters deal steps, settles bankroll.
// Optional macro BANKER_COMMISSION_EN (see baccarat_payout) enables banker commission.
module baccarat_round_ctrl
  import baccarat_pkg::*;
#(
  parameter int BANK_W    = 16,
  parameter int INIT_BANK = 1000,
  parameter int MAX_BET   = 100,
  parameter int MAX_STEPS = 12,
  parameter int CNT_W     = 8
) (
  input  logic              slow_clock,
  input  logic              resetb,
  input  logic              bet_valid,
  input  logic [1:0]        bet_side,
  input  logic [7:0]        bet_amt,
  input  logic              step_req,
  input  logic              player_win_light,
  input  logic              dealer_win_light,
  output logic              deal_resetb,
  output logic              dealer_step,
  output logic              bet_ack,
  output logic              bet_reject,
  output logic [BANK_W-1:0] bankroll,
  output logic [1:0]        last_result,
  output logic              result_valid,
  output logic [CNT_W-1:0]  player_wins,
  output logic [CNT_W-1:0]  dealer_wins,
  output logic [CNT_W-1:0]  ties,
  output logic [CNT_W-1:0]  rounds,
  output logic              broke,
  output logic              error
);

  localparam int SC_W = $clog2(MAX_STEPS + 1);

  state_t            state;
  logic [1:0]        side_q, res_q;
  logic [7:0]        amt_q;
  logic [SC_W-1:0]   step_cnt;
  logic [BANK_W-1:0] settled_bank;
  logic              bet_legal;

  assign bet_legal = (bet_side != 2'd0) && (bet_amt != 8'd0) &&
                     (bet_amt <= 8'(MAX_BET)) && (BANK_W'(bet_amt) <= bankroll);

  baccarat_payout #(.BANK_W(BANK_W)) u_payout (
    .side        (side_q),
    .amt         (amt_q),
    .result      (res_q),
    .bankroll    (bankroll),
    .new_bankroll(settled_bank)
  );

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state        <= ST_BET;
      bankroll     <= BANK_W'(INIT_BANK);
      side_q       <= '0;
      amt_q        <= '0;
      res_q        <= RES_NONE;
      step_cnt     <= '0;
      last_result  <= RES_NONE;
      player_wins  <= '0;
      dealer_wins  <= '0;
      ties         <= '0;
      rounds       <= '0;
      deal_resetb  <= 1'b0;
      dealer_step  <= 1'b0;
      bet_ack      <= 1'b0;
      bet_reject   <= 1'b0;
      result_valid <= 1'b0;
      broke        <= 1'b0;
      error        <= 1'b0;
    end else begin
      bet_ack      <= 1'b0;
      bet_reject   <= 1'b0;
      dealer_step  <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        ST_BET: begin
          if (bankroll == '0) begin
            state <= ST_BROKE;
            broke <= 1'b1;
          end else if (bet_valid) begin
            if (bet_legal) begin
              bet_ack     <= 1'b1;
              bankroll    <= bankroll - BANK_W'(bet_amt);
              side_q      <= bet_side;
              amt_q       <= bet_amt;
              step_cnt    <= '0;
              deal_resetb <= 1'b1;
              state       <= ST_DEAL;
            end else begin
              bet_reject <= 1'b1;
            end
          end
        end
        ST_DEAL: begin
          // Lights win over a same-cycle step request, which is dropped.
          if (player_win_light || dealer_win_light) begin
            res_q       <= {dealer_win_light, player_win_light};
            deal_resetb <= 1'b0;
            state       <= ST_SETTLE;
          end else if (step_cnt == SC_W'(MAX_STEPS)) begin
            deal_resetb <= 1'b0;
            error       <= 1'b1;
            state       <= ST_ERR;
          end else if (step_req && !dealer_step) begin
            dealer_step <= 1'b1;
            step_cnt    <= step_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          bankroll     <= settled_bank;
          last_result  <= res_q;
          result_valid <= 1'b1;
          if (rounds != '1) rounds <= rounds + 1'b1;
          case (res_q)
            RES_PLAYER: if (player_wins != '1) player_wins <= player_wins + 1'b1;
            RES_BANKER: if (dealer_wins != '1) dealer_wins <= dealer_wins + 1'b1;
            RES_TIE:    if (ties != '1) ties <= ties + 1'b1;
            default: ;
          endcase
          state <= ST_SHOW;
        end
        ST_SHOW: if (step_req) state <= ST_BET;
        ST_BROKE, ST_ERR: ;
        default: state <= ST_BET;
      endcase
    end
  end

endmodule
